// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode-0 slave with synchronized inputs and RX holding register or FIFO
//
// Optional feature macro: SPI_SLAVE_RX_FIFO_EN (4-entry RX FIFO instead of a single RX register).
//
// Ports:
//   raw_clk   in   single clock, all flops on its rising edge
//   reset     in   synchronous active-high reset
//   cs_n      in   asynchronous chip select, active low
//   sclk      in   asynchronous SPI clock (CPOL=0, CPHA=0)
//   mosi      in   asynchronous serial data in, MSB first
//   miso      out  serial data out, MSB first, 0 while cs_n is high
//   width_16  in   1 = 16-bit words, 0 = 8-bit words (latched at transfer start)
//   data_tx   in   transmit word, [7:0] used in 8-bit mode
//   tx_load   in   strobe: data_tx -> TX holding register
//   data_rx   out  received word, zero-extended in 8-bit mode
//   rx_valid  out  data_rx holds an unconsumed word
//   rx_ack    in   strobe: consume data_rx
//   busy      out  transfer in progress (state SHIFT)
//   overrun   out  sticky: a received word was dropped
module spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        raw_clk,
    input  logic        reset,
    input  logic        cs_n,
    input  logic        sclk,
    input  logic        mosi,
    output logic        miso,
    input  logic        width_16,
    input  logic [15:0] data_tx,
    input  logic        tx_load,
    output logic [15:0] data_rx,
    output logic        rx_valid,
    input  logic        rx_ack,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q, fill_q;
    logic                   cs_prev_q, sclk_prev_q, armed_q;
    logic                   width_q, miso_q;
    logic [15:0]            tx_hold_q, tx_shift_q;
    logic [14:0]            rx_shift_q;
    logic [3:0]             cnt_q;

    logic        cs_s, sclk_s, mosi_s;
    logic        cs_fall, cs_rise, sclk_rise, sclk_fall;
    logic [3:0]  last_cnt;
    logic        word_done;
    logic [15:0] rx_word;

    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // The cs chain is preset high on reset; armed_q blocks a false falling edge
    // while that preset drains out, so a reset mid-transfer waits for a fresh select.
    assign cs_fall   = armed_q & cs_prev_q & ~cs_s;
    assign cs_rise   = ~cs_prev_q & cs_s;
    assign sclk_rise = ~sclk_prev_q & sclk_s;
    assign sclk_fall = sclk_prev_q & ~sclk_s;

    assign last_cnt  = width_q ? 4'd15 : 4'd7;
    assign word_done = (state_q == SHIFT) && !cs_rise && sclk_rise && (cnt_q == last_cnt);
    assign rx_word   = width_q ? {rx_shift_q, mosi_s} : {8'h00, rx_shift_q[6:0], mosi_s};

    assign miso = miso_q & ~cs_n;
    assign busy = (state_q == SHIFT);

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            fill_q      <= '0;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
            armed_q     <= 1'b0;
            state_q     <= IDLE;
            width_q     <= 1'b0;
            miso_q      <= 1'b0;
            tx_hold_q   <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            cnt_q       <= '0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            cs_prev_q   <= cs_s;
            sclk_prev_q <= sclk_s;
            if (fill_q[SYNC_STAGES-1] && cs_s) begin
                armed_q <= 1'b1;
            end
            if (tx_load) begin
                tx_hold_q <= data_tx;
            end
            case (state_q)
                IDLE: begin
                    miso_q <= 1'b0;
                    if (cs_fall) begin
                        state_q    <= SHIFT;
                        width_q    <= width_16;
                        tx_shift_q <= tx_hold_q;
                        cnt_q      <= '0;
                        miso_q     <= width_16 ? tx_hold_q[15] : tx_hold_q[7];
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        miso_q  <= 1'b0;
                    end else if (sclk_rise) begin
                        rx_shift_q <= {rx_shift_q[13:0], mosi_s};
                        if (cnt_q == last_cnt) begin
                            cnt_q      <= '0;
                            tx_shift_q <= tx_hold_q;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end else if (sclk_fall) begin
                        // cnt_q bits already sampled; the next one counts down from the MSB.
                        miso_q <= tx_shift_q[last_cnt - cnt_q];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SPI_SLAVE_RX_FIFO_EN
    logic [15:0] fifo_q [4];
    logic [1:0]  wr_ptr_q, rd_ptr_q;
    logic [2:0]  count_q;
    logic        fifo_pop, fifo_push, fifo_full;

    assign fifo_full = (count_q == 3'd4);
    assign fifo_pop  = rx_ack && (count_q != 3'd0);
    assign fifo_push = word_done && (!fifo_full || fifo_pop);
    assign rx_valid  = (count_q != 3'd0);
    assign data_rx   = rx_valid ? fifo_q[rd_ptr_q] : 16'h0000;

    always_ff @(posedge raw_clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun   <= 1'b0;
        end else begin
            if (fifo_push) begin
                fifo_q[wr_ptr_q] <= rx_word;
                wr_ptr_q         <= wr_ptr_q + 2'd1;
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            count_q <= count_q + {2'b00, fifo_push} - {2'b00, fifo_pop};
            if (word_done && fifo_full && !fifo_pop) begin
                overrun <= 1'b1;
            end
        end
    end
`else
    always_ff @(posedge raw_clk) begin
        if (reset) begin
            data_rx  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else if (word_done) begin
            // An ack in the completion cycle frees the register for the new word.
            if (rx_valid && !rx_ack) begin
                overrun <= 1'b1;
            end else begin
                data_rx  <= rx_word;
                rx_valid <= 1'b1;
            end
        end else if (rx_ack) begin
            rx_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - self-checking bench for spi_slave against a transaction-level model
module tb_spi_slave;

    localparam int SYNC = 2;
    localparam int HALF = 8;

    logic        raw_clk = 1'b0;
    logic        reset, cs_n, sclk, mosi, miso, width_16, tx_load, rx_valid, rx_ack, busy, overrun;
    logic [15:0] data_tx, data_rx;

    int checks = 0;
    int errors = 0;

    spi_slave #(.SYNC_STAGES(SYNC)) dut (
        .raw_clk(raw_clk), .reset(reset), .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .miso(miso),
        .width_16(width_16), .data_tx(data_tx), .tx_load(tx_load), .data_rx(data_rx),
        .rx_valid(rx_valid), .rx_ack(rx_ack), .busy(busy), .overrun(overrun)
    );

    always #5 raw_clk = ~raw_clk;

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge raw_clk);
        reset = 1'b0;
        @(negedge raw_clk);
    endtask

    task automatic load_tx(input logic [15:0] w);
        data_tx = w;
        tx_load = 1'b1;
        @(negedge raw_clk);
        tx_load = 1'b0;
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        @(negedge raw_clk);
        rx_ack = 1'b0;
        @(negedge raw_clk);
    endtask

    task automatic cs_low(input logic w16);
        width_16 = w16;
        cs_n = 1'b0;
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge raw_clk);
        cs_n = 1'b1;
        repeat (2 * HALF) @(negedge raw_clk);
    endtask

    // Master side of one word: mosi changes with sclk low, miso sampled at the rising edge.
    // With ack_last the rx_ack pulse lands in the cycle the slave completes the word.
    task automatic spi_word(input logic [15:0] w, input int nbits, input bit ack_last,
                            output logic [15:0] got);
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = w[nbits-1-i];
            repeat (HALF) @(negedge raw_clk);
            got  = {got[14:0], miso};
            sclk = 1'b1;
            if (ack_last && i == nbits - 1) begin
                repeat (SYNC) @(negedge raw_clk);
                rx_ack = 1'b1;
                @(negedge raw_clk);
                rx_ack = 1'b0;
                repeat (HALF - SYNC - 1) @(negedge raw_clk);
            end else begin
                repeat (HALF) @(negedge raw_clk);
            end
            sclk = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cs_n = 1'b1; sclk = 1'b0; mosi = 1'b1; width_16 = 1'b1;
        data_tx = 16'hFFFF; tx_load = 1'b1; rx_ack = 1'b1;
        repeat (4) @(negedge raw_clk);
        tx_load = 1'b0; rx_ack = 1'b0; mosi = 1'b0;
        checks++; if (data_rx !== 16'h0) begin errors++; $display("FAIL reset_data_rx: got %h expected 0000", data_rx); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", miso); end
        reset = 1'b0;
        @(negedge raw_clk);
    endtask

    task automatic test_basic_8bit();
        logic [15:0] got;
        do_reset();
        load_tx(16'h00A5);
        cs_low(1'b0);
        repeat (5) @(negedge raw_clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b8_busy: got %b expected 1", busy); end
        spi_word(16'h003C, 8, 1'b0, got);
        cs_high();
        checks++; if (got !== 16'h00A5) begin errors++; $display("FAIL b8_miso: got %h expected 00a5", got); end
        checks++; if (data_rx !== 16'h003C) begin errors++; $display("FAIL b8_data_rx: got %h expected 003c", data_rx); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL b8_rx_valid: got %b expected 1", rx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b8_busy_end: got %b expected 0", busy); end
        ack_pulse();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL b8_ack: got %b expected 0", rx_valid); end
    endtask

    task automatic test_basic_16bit();
        logic [15:0] got;
        do_reset();
        load_tx(16'hBEEF);
        cs_low(1'b1);
        spi_word(16'h1234, 16, 1'b0, got);
        cs_high();
        checks++; if (got !== 16'hBEEF) begin errors++; $display("FAIL b16_miso: got %h expected beef", got); end
        checks++; if (data_rx !== 16'h1234) begin errors++; $display("FAIL b16_data_rx: got %h expected 1234", data_rx); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL b16_rx_valid: got %b expected 1", rx_valid); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] got;
        do_reset();
        cs_low(1'b0);
        spi_word(16'h0011, 8, 1'b0, got);
        spi_word(16'h0022, 8, 1'b0, got);
        cs_high();
        checks++; if (data_rx !== 16'h0011) begin errors++; $display("FAIL b2b_first: got %h expected 0011", data_rx); end
`ifdef SPI_SLAVE_RX_FIFO_EN
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
        ack_pulse();
        checks++; if (data_rx !== 16'h0022 || rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_second: got %h/%b expected 0022/1", data_rx, rx_valid); end
        ack_pulse();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b expected 0", rx_valid); end
`else
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun: got %b expected 1", overrun); end
        ack_pulse();
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_sticky: got %b expected 1", overrun); end
`endif
    endtask

    task automatic test_abort();
        logic [15:0] got;
        do_reset();
        load_tx(16'h0096);
        cs_low(1'b0);
        spi_word(16'h0015, 5, 1'b0, got);
        cs_high();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b expected 0", rx_valid); end
        cs_low(1'b0);
        spi_word(16'h0081, 8, 1'b0, got);
        cs_high();
        checks++; if (data_rx !== 16'h0081 || rx_valid !== 1'b1) begin errors++; $display("FAIL abort_next: got %h/%b expected 0081/1", data_rx, rx_valid); end
        checks++; if (got !== 16'h0096) begin errors++; $display("FAIL abort_miso: got %h expected 0096", got); end
    endtask

    task automatic test_ack_coincident();
        logic [15:0] got;
        do_reset();
        cs_low(1'b0);
        spi_word(16'h0011, 8, 1'b0, got);
        spi_word(16'h0022, 8, 1'b1, got);
        repeat (2) @(negedge raw_clk);
        checks++; if (data_rx !== 16'h0022) begin errors++; $display("FAIL coinc_data: got %h expected 0022", data_rx); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL coinc_valid: got %b expected 1", rx_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL coinc_overrun: got %b expected 0", overrun); end
        cs_high();
    endtask

    task automatic test_reset_mid();
        logic [15:0] got;
        do_reset();
        load_tx(16'h00FF);
        cs_low(1'b0);
        spi_word(16'h0077, 8, 1'b0, got);
        spi_word(16'h000F, 4, 1'b0, got);
        repeat (4) @(negedge raw_clk);
        reset = 1'b1;
        repeat (2) @(negedge raw_clk);
        checks++; if ({miso, rx_valid, busy, overrun} !== 4'b0000) begin errors++; $display("FAIL rstmid_flags: got %b expected 0000", {miso, rx_valid, busy, overrun}); end
        checks++; if (data_rx !== 16'h0) begin errors++; $display("FAIL rstmid_data: got %h expected 0000", data_rx); end
        reset = 1'b0;
        cs_high();
        load_tx(16'h00C6);
        cs_low(1'b0);
        spi_word(16'h005A, 8, 1'b0, got);
        cs_high();
        checks++; if (data_rx !== 16'h005A || rx_valid !== 1'b1) begin errors++; $display("FAIL rstmid_next: got %h/%b expected 005a/1", data_rx, rx_valid); end
        checks++; if (got !== 16'h00C6) begin errors++; $display("FAIL rstmid_miso: got %h expected 00c6", got); end
    endtask

    task automatic test_tx_load_shift();
        logic [15:0] got1, got2;
        do_reset();
        load_tx(16'h00C3);
        cs_low(1'b0);
        repeat (5) @(negedge raw_clk);
        load_tx(16'h005E);
        spi_word(16'h0001, 8, 1'b1, got1);
        spi_word(16'h0002, 8, 1'b0, got2);
        cs_high();
        checks++; if (got1 !== 16'h00C3) begin errors++; $display("FAIL txload_cur: got %h expected 00c3", got1); end
        checks++; if (got2 !== 16'h005E) begin errors++; $display("FAIL txload_next: got %h expected 005e", got2); end
    endtask

    // Each transaction: model expects miso = loaded word truncated to the width,
    // data_rx = master word zero-extended, then an ack empties the slot.
    task automatic test_random();
        logic [15:0] tx, rx, got, exp_tx, exp_rx;
        logic        w16;
        int          nb;
        do_reset();
        for (int n = 0; n < 8; n++) begin
            tx  = 16'($urandom);
            rx  = 16'($urandom);
            w16 = 1'($urandom_range(0, 1));
            nb  = w16 ? 16 : 8;
            exp_tx = w16 ? tx : {8'h00, tx[7:0]};
            exp_rx = w16 ? rx : {8'h00, rx[7:0]};
            load_tx(tx);
            cs_low(w16);
            spi_word(rx, nb, 1'b0, got);
            cs_high();
            checks++; if (got !== exp_tx) begin errors++; $display("FAIL rand_miso[%0d]: got %h expected %h", n, got, exp_tx); end
            checks++; if (data_rx !== exp_rx || rx_valid !== 1'b1) begin errors++; $display("FAIL rand_rx[%0d]: got %h/%b expected %h/1", n, data_rx, rx_valid, exp_rx); end
            ack_pulse();
        end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rand_overrun: got %b expected 0", overrun); end
    endtask

    initial begin
        test_reset();
        test_basic_8bit();
        test_basic_16bit();
        test_back_to_back();
        test_abort();
        test_ack_coincident();
        test_reset_mid();
        test_tx_load_shift();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
- REQ-001 The module SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth for cs_n, sclk and mosi (legal values 2..3).
- REQ-002 The module SHALL have port raw_clk, input, 1 bit: the single clock; every flop is on its rising edge.
- REQ-003 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
- REQ-004 The module SHALL have port cs_n, input, 1 bit: asynchronous chip select from the external master, active low.
- REQ-005 The module SHALL have port sclk, input, 1 bit: asynchronous SPI clock, mode 0 (CPOL=0, CPHA=0).
- REQ-006 The module SHALL have port mosi, input, 1 bit: asynchronous serial data in, MSB first.
- REQ-007 The module SHALL have port miso, output, 1 bit: serial data out, MSB first; driven 0 while cs_n is high.
- REQ-008 The module SHALL have port width_16, input, 1 bit: 1 selects 16-bit words, 0 selects 8-bit words.
- REQ-009 The module SHALL have port data_tx, input, 16 bits: the transmit word; 8-bit mode uses [7:0].
- REQ-010 The module SHALL have port tx_load, input, 1 bit: a 1-cycle strobe that copies data_tx into the TX holding register.
- REQ-011 The module SHALL have port data_rx, output, 16 bits: the received word, zero-extended in 8-bit mode.
- REQ-012 The module SHALL have port rx_valid, output, 1 bit: data_rx is valid.
- REQ-013 The module SHALL have port rx_ack, input, 1 bit: a 1-cycle strobe that consumes data_rx.
- REQ-014 The module SHALL have port busy, output, 1 bit: high while the module is in state SHIFT.
- REQ-015 The module SHALL have port overrun, output, 1 bit: sticky; set when a received word is lost.

Function
- REQ-016 cs_n, sclk and mosi SHALL each pass through a SYNC_STAGES-deep flop chain, and edges SHALL be detected on the synchronized values only.
- REQ-017 The state machine SHALL have two states, IDLE and SHIFT.
  - IDLE -> SHIFT on a synchronized cs_n falling edge.
  - SHIFT -> IDLE on a synchronized cs_n rising edge.
- REQ-018 On IDLE -> SHIFT the module SHALL, in the same cycle:
  - latch width_16 into the word-width register;
  - copy the TX holding register into the shift register;
  - clear the bit counter;
  - present the word MSB (bit 15 or bit 7) on miso.
- REQ-019 On a synchronized sclk rising edge in SHIFT, the module SHALL shift mosi into the RX shift LSB and increment the bit counter.
- REQ-020 On a synchronized sclk falling edge in SHIFT, the module SHALL present the next TX bit on miso.
- REQ-021 Word completion occurs when the bit counter reaches 8 (8-bit) or 16 (16-bit); data_rx and rx_valid SHALL be updated 1 raw_clk after the sampling edge.
- REQ-022 On word completion with cs_n still low, the counter SHALL wrap to 0 and the TX holding register SHALL be reloaded into the shift register (back-to-back words).
- REQ-023 If cs_n rises mid-word, the partial word SHALL be discarded with no rx_valid, and the counter SHALL clear.
- REQ-024 rx_ack SHALL clear rx_valid in the next cycle; rx_ack while rx_valid is low SHALL be ignored.
- REQ-025 If a word completes while rx_valid=1 and no rx_ack arrives in the same cycle, data_rx SHALL be kept unchanged, the new word dropped, and overrun set.
- REQ-026 If word completion and rx_ack coincide, the new word SHALL replace data_rx, rx_valid SHALL stay 1, and overrun SHALL be unchanged.
- REQ-027 overrun SHALL clear only on reset.
- REQ-028 tx_load during SHIFT SHALL update only the holding register; the current word is unaffected.
- REQ-029 Correct operation SHALL be guaranteed for sclk up to raw_clk/8.

Reset
- REQ-030 While reset=1, on each raw_clk edge the module SHALL:
  - go to IDLE;
  - set miso=0, rx_valid=0, busy=0, overrun=0, data_rx=0;
  - clear the TX holding register, shift registers and counter;
  - preset the synchronizers to cs_n=1, sclk=0, mosi=0.
- REQ-031 A reset in the middle of a transfer SHALL abort it, and the module SHALL wait for a fresh cs_n falling edge.

Configuration
- REQ-032 With SPI_SLAVE_RX_FIFO_EN defined, received words SHALL go into a 4-entry FIFO.
  - data_rx = head entry; rx_valid = not empty; rx_ack pops one entry.
  - overrun is set only when a word completes while the FIFO is full, with no pop in the same cycle.
  - A push and a pop in the same cycle SHALL keep the occupancy unchanged.
- REQ-033 Without SPI_SLAVE_RX_FIFO_EN, a single RX register SHALL be used, per REQ-021..REQ-027.

Verification
- REQ-034 8-bit: tx_load data_tx=0x00A5; master sends 0x3C -> miso returns 0xA5, data_rx=0x003C, rx_valid=1.
- REQ-035 16-bit: data_tx=0xBEEF; master sends 0x1234 -> miso returns 0xBEEF, data_rx=0x1234.
- REQ-036 Two back-to-back 8-bit words 0x11, 0x22 under one cs_n low, no rx_ack -> data_rx=0x11, overrun=1 (no FIFO); with the FIFO, both words pop in order and overrun=0.
- REQ-037 cs_n raised after 5 bits -> rx_valid stays 0; the next full word 0x81 is received correctly.
- REQ-038 Word completion coincident with rx_ack -> data_rx holds the new word, rx_valid=1, overrun=0.
- REQ-039 reset asserted after 4 bits of 0xF0 -> all outputs return to 0; the next transfer 0x5A is received intact.
